// File: rtl/bbox_frag_scanner.sv
// Bounding-box fragment scanner: walks every lattice point of an accepted box,
// one fragment per cycle on a ready/valid stream, in raster or serpentine order.
module bbox_frag_scanner #(
    parameter int COORD_W    = 11,
    parameter int XSTEP      = 1,
    parameter int YSTEP      = 1,
    parameter int SERPENTINE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] min_x,
    input  logic [COORD_W-1:0] max_x,
    input  logic [COORD_W-1:0] min_y,
    input  logic [COORD_W-1:0] max_y,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_first,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [COORD_W:0] XSTEP_W = (COORD_W+1)'(XSTEP);
    localparam logic [COORD_W:0] YSTEP_W = (COORD_W+1)'(YSTEP);
    localparam bit               SERP    = (SERPENTINE != 0);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic [COORD_W-1:0] min_x_q, max_x_q, max_y_q;
    logic               row_q;
    logic               first_q;

    logic               accept, degen, adv;
    logic               reverse, next_rev;
    logic [COORD_W:0]   x_ext, nx_fwd, nx_rev, rev_lim, ny;
    logic               row_more, col_more, box_end;
    logic [COORD_W-1:0] row_start_x;

    assign accept = in_valid && (state_q == IDLE);
    assign degen  = (min_x > max_x) || (min_y > max_y);
    assign adv    = (state_q == SCAN) && out_ready;

    // All step arithmetic runs one bit wider so bounds at the max code cannot wrap.
    assign reverse  = SERP && row_q;
    assign next_rev = SERP && !row_q;
    assign x_ext    = {1'b0, x_q};
    assign nx_fwd   = x_ext + XSTEP_W;
    assign nx_rev   = x_ext - XSTEP_W;
    assign rev_lim  = {1'b0, min_x_q} + XSTEP_W;
    assign ny       = {1'b0, y_q} + YSTEP_W;
    assign row_more = reverse ? (x_ext >= rev_lim) : (nx_fwd <= {1'b0, max_x_q});
    assign col_more = (ny <= {1'b0, max_y_q});
    assign box_end  = !row_more && !col_more;

    // A reverse row starts where the forward row ended: that x is already the
    // row's last lattice point, so no division by XSTEP is needed.
    assign row_start_x = next_rev ? x_q : min_x_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !degen) state_d = SCAN;
            SCAN: begin
                if (abort)                 state_d = IDLE;
                else if (adv && box_end)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SCAN);
        out_valid = (state_q == SCAN);
        out_first = (state_q == SCAN) && first_q;
        out_last  = (state_q == SCAN) && box_end;
        out_x     = x_q;
        out_y     = y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            row_q   <= 1'b0;
            first_q <= 1'b0;
        end else if (accept && !degen) begin
            x_q     <= min_x;
            y_q     <= min_y;
            min_x_q <= min_x;
            max_x_q <= max_x;
            max_y_q <= max_y;
            row_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (adv && !abort) begin
            first_q <= 1'b0;
            if (row_more) begin
                x_q <= reverse ? nx_rev[COORD_W-1:0] : nx_fwd[COORD_W-1:0];
            end else if (col_more) begin
                y_q   <= ny[COORD_W-1:0];
                row_q <= ~row_q;
                x_q   <= row_start_x;
            end
        end
    end

endmodule

// File: tb/tb_bbox_frag_scanner.sv
// Self-checking bench: three scanner configurations (raster, serpentine, stepped
// serpentine) driven by a vector table, corner sequences and random boxes.
module tb_bbox_frag_scanner;

    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid [3];
    logic          abort    [3];
    logic          out_ready[3];
    logic [CW-1:0] min_x[3], max_x[3], min_y[3], max_y[3];
    logic          in_ready [3];
    logic          out_valid[3];
    logic          out_first[3];
    logic          out_last [3];
    logic          busy     [3];
    logic [CW-1:0] out_x[3], out_y[3];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    bbox_frag_scanner #(.COORD_W(CW), .XSTEP(1), .YSTEP(1), .SERPENTINE(0)) u_ras (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .min_x(min_x[0]), .max_x(max_x[0]), .min_y(min_y[0]), .max_y(max_y[0]),
        .abort(abort[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_x(out_x[0]), .out_y(out_y[0]), .out_first(out_first[0]),
        .out_last(out_last[0]), .busy(busy[0]));

    bbox_frag_scanner #(.COORD_W(CW), .XSTEP(1), .YSTEP(1), .SERPENTINE(1)) u_ser (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .min_x(min_x[1]), .max_x(max_x[1]), .min_y(min_y[1]), .max_y(max_y[1]),
        .abort(abort[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_x(out_x[1]), .out_y(out_y[1]), .out_first(out_first[1]),
        .out_last(out_last[1]), .busy(busy[1]));

    bbox_frag_scanner #(.COORD_W(CW), .XSTEP(3), .YSTEP(2), .SERPENTINE(1)) u_stp (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .min_x(min_x[2]), .max_x(max_x[2]), .min_y(min_y[2]), .max_y(max_y[2]),
        .abort(abort[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_x(out_x[2]), .out_y(out_y[2]), .out_first(out_first[2]),
        .out_last(out_last[2]), .busy(busy[2]));

    typedef struct {
        int d;
        int x0, x1, y0, y1;
        int stall;
        int n;
        int ex[8];
        int ey[8];
    } vec_t;

    vec_t tbl[11];

    function automatic int xstep_of(int d); return (d == 2) ? 3 : 1; endfunction
    function automatic int ystep_of(int d); return (d == 2) ? 2 : 1; endfunction
    function automatic bit serp_of(int d);  return (d != 0);         endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: enumerate rows top-down, list the row's lattice x values, flip odd rows.
    task automatic model_box(int d, int x0, int x1, int y0, int y1);
        int row[$];
        int r;
        exp_x.delete();
        exp_y.delete();
        if (x0 > x1 || y0 > y1) return;
        r = 0;
        for (int y = y0; y <= y1; y += ystep_of(d)) begin
            row.delete();
            for (int x = x0; x <= x1; x += xstep_of(d)) row.push_back(x);
            if (serp_of(d) && (r % 2 == 1)) row.reverse();
            foreach (row[i]) begin
                exp_x.push_back(row[i]);
                exp_y.push_back(y);
            end
            r++;
        end
    endtask

    task automatic send_box(int d, int x0, int x1, int y0, int y1);
        min_x[d]    = CW'(x0);
        max_x[d]    = CW'(x1);
        min_y[d]    = CW'(y0);
        max_y[d]    = CW'(y1);
        in_valid[d] = 1'b1;
    endtask

    // Offers the box, then checks the stream against exp_x/exp_y under the stall mode
    // (0 always ready, 1 ready pattern 1,0,0 repeating, 2 random).
    task automatic drive_check(int d, int x0, int x1, int y0, int y1, int stall, string nm);
        int n, idx, cyc;
        bit rdy;
        n = exp_x.size();
        @(negedge clk);
        chk($sformatf("%s in_ready_before", nm), int'(in_ready[d]), 1);
        send_box(d, x0, x1, y0, y1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 8 * n + 16) begin
            chk($sformatf("%s[%0d] valid", nm, idx), int'(out_valid[d]), 1);
            chk($sformatf("%s[%0d] x", nm, idx), int'(out_x[d]), exp_x[idx]);
            chk($sformatf("%s[%0d] y", nm, idx), int'(out_y[d]), exp_y[idx]);
            chk($sformatf("%s[%0d] first", nm, idx), int'(out_first[d]), int'(idx == 0));
            chk($sformatf("%s[%0d] last", nm, idx), int'(out_last[d]), int'(idx == n - 1));
            chk($sformatf("%s[%0d] in_ready", nm, idx), int'(in_ready[d]), 0);
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom % 4 != 0);
            endcase
            out_ready[d] = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        out_ready[d] = 1'b1;
        if (idx < n) chk($sformatf("%s timeout_frags", nm), idx, n);
        chk($sformatf("%s end valid", nm), int'(out_valid[d]), 0);
        chk($sformatf("%s end in_ready", nm), int'(in_ready[d]), 1);
        chk($sformatf("%s end busy", nm), int'(busy[d]), 0);
    endtask

    task automatic check_reset_state(string nm);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d in_ready", nm, d), int'(in_ready[d]), 1);
            chk($sformatf("%s d%0d valid", nm, d), int'(out_valid[d]), 0);
            chk($sformatf("%s d%0d x", nm, d), int'(out_x[d]), 0);
            chk($sformatf("%s d%0d y", nm, d), int'(out_y[d]), 0);
            chk($sformatf("%s d%0d first", nm, d), int'(out_first[d]), 0);
            chk($sformatf("%s d%0d last", nm, d), int'(out_last[d]), 0);
            chk($sformatf("%s d%0d busy", nm, d), int'(busy[d]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 2, 4, 3, 4, 0, 6, '{2,3,4,2,3,4,0,0}, '{3,3,3,4,4,4,0,0}};
        tbl[1]  = '{1, 2, 4, 3, 4, 0, 6, '{2,3,4,4,3,2,0,0}, '{3,3,3,4,4,4,0,0}};
        tbl[2]  = '{2, 0, 6, 0, 2, 0, 6, '{0,3,6,6,3,0,0,0}, '{0,0,0,2,2,2,0,0}};
        tbl[3]  = '{0, 2, 4, 3, 4, 1, 6, '{2,3,4,2,3,4,0,0}, '{3,3,3,4,4,4,0,0}};
        tbl[4]  = '{1, 2, 4, 3, 4, 1, 6, '{2,3,4,4,3,2,0,0}, '{3,3,3,4,4,4,0,0}};
        tbl[5]  = '{0, 1, 1, 1, 1, 0, 1, '{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,0}};
        tbl[6]  = '{0, 2046, 2047, 2046, 2047, 0, 4,
                    '{2046,2047,2046,2047,0,0,0,0}, '{2046,2046,2047,2047,0,0,0,0}};
        tbl[7]  = '{1, 2046, 2047, 2046, 2047, 1, 4,
                    '{2046,2047,2047,2046,0,0,0,0}, '{2046,2046,2047,2047,0,0,0,0}};
        tbl[8]  = '{2, 2040, 2047, 2044, 2047, 0, 6,
                    '{2040,2043,2046,2046,2043,2040,0,0}, '{2044,2044,2044,2046,2046,2046,0,0}};
        tbl[9]  = '{2, 2045, 2047, 2047, 2047, 0, 1, '{2045,0,0,0,0,0,0,0}, '{2047,0,0,0,0,0,0,0}};
        tbl[10] = '{1, 0, 0, 0, 3, 0, 4, '{0,0,0,0,0,0,0,0}, '{0,1,2,3,0,0,0,0}};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; abort[d] = 1'b0; out_ready[d] = 1'b1;
            min_x[d] = '0; max_x[d] = '0; min_y[d] = '0; max_y[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        foreach (tbl[i]) begin
            exp_x.delete();
            exp_y.delete();
            for (int k = 0; k < tbl[i].n; k++) begin
                exp_x.push_back(tbl[i].ex[k]);
                exp_y.push_back(tbl[i].ey[k]);
            end
            drive_check(tbl[i].d, tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1,
                        tbl[i].stall, $sformatf("tbl%0d", i));
        end

        // Degenerate boxes: consumed with no fragments, in_ready high next cycle.
        exp_x.delete(); exp_y.delete();
        drive_check(0, 5, 4, 0, 9, 0, "degen_x");
        drive_check(2, 0, 0, 5, 4, 0, "degen_y");
        @(negedge clk);
        chk("degen quiet valid", int'(out_valid[0]), 0);

        // Abort on the third fragment of a large box.
        @(negedge clk);
        send_box(0, 0, 9, 0, 9);
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort frag3 x", int'(out_x[0]), 2);
        chk("abort frag3 valid", int'(out_valid[0]), 1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort valid", int'(out_valid[0]), 0);
        chk("abort in_ready", int'(in_ready[0]), 1);
        model_box(0, 1, 1, 1, 1);
        drive_check(0, 1, 1, 1, 1, 0, "post_abort");

        // Abort while idle must not block a simultaneous accept.
        @(negedge clk);
        send_box(0, 3, 3, 3, 3);
        abort[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        abort[0] = 1'b0;
        chk("idle_abort valid", int'(out_valid[0]), 1);
        chk("idle_abort x", int'(out_x[0]), 3);
        chk("idle_abort first", int'(out_first[0]), 1);
        chk("idle_abort last", int'(out_last[0]), 1);
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("idle_abort done", int'(in_ready[0]), 1);

        // Reset in the middle of a box.
        @(negedge clk);
        send_box(1, 0, 5, 0, 5);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst busy", int'(busy[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        model_box(1, 1, 1, 1, 1);
        drive_check(1, 1, 1, 1, 1, 0, "post_rst");

        // Random boxes, some near the top code, some degenerate, random backpressure.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 25; t++) begin
                int x0, x1, y0, y1;
                x0 = ($urandom % 4 == 0) ? 2047 - int'($urandom_range(0, 8)) : int'($urandom_range(0, 2040));
                y0 = ($urandom % 4 == 0) ? 2047 - int'($urandom_range(0, 8)) : int'($urandom_range(0, 2040));
                x1 = x0 + int'($urandom_range(0, 9));
                y1 = y0 + int'($urandom_range(0, 7));
                if (x1 > 2047) x1 = 2047;
                if (y1 > 2047) y1 = 2047;
                if ($urandom % 10 == 0 && x0 > 0) x1 = x0 - 1;
                model_box(d, x0, x1, y0, y1);
                drive_check(d, x0, x1, y0, y1, ($urandom % 2 == 0) ? 2 : 0,
                            $sformatf("rnd_d%0d_%0d", d, t));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
